// File: rtl/dual_port_sram_pkg.sv
// Shared constants and types for the parametrised dual-port SRAM.
//   READ_ASYNC / READ_SYNC          : values for the READ_MODE parameter
//   RDW_WRITE_FIRST / RDW_READ_FIRST: values for the RDW_MODE parameter
//   sram_state_e                    : clear-sequencer FSM encoding
package dual_port_sram_pkg;

  localparam int READ_ASYNC      = 0;
  localparam int READ_SYNC       = 1;
  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_e;

endpackage

// File: rtl/sram_init_ctrl.sv
// Post-reset clear sequencer. After rst releases it walks a counter over
// 0..DEPTH-1, one word per cycle, then parks in READY until the next reset.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr_we     : clear write enable (high for exactly DEPTH cycles)
//   clr_addr   : word being cleared this cycle
//   init_busy  : port unavailable while the clear runs
module sram_init_ctrl
  import dual_port_sram_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_busy
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  sram_state_e       state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      case (state)
        INIT: begin
          if (cnt == LAST) begin
            state <= READY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: state <= READY;
      endcase
    end
  end

  // Outputs come straight from state flops, so they are glitch-free.
  assign clr_we    = (state == INIT);
  assign init_busy = (state == INIT);
  assign clr_addr  = cnt;

endmodule

// File: rtl/dual_port_sram_param.sv
// Parametrised 1W/1R SRAM on a single clock.
//   - READ_MODE selects combinational or 1-cycle registered read.
//   - RDW_MODE picks write-first or read-first for same-address collisions
//     in registered mode.
//   - A clear sequence after reset fills every word with CLEAR_VAL, so no
//     location ever reads X.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   w_en, ad_wr, wr_d : write port
//   r_en, ad_rd       : read request
//   rd_d, rd_valid    : read data and its qualifier
//   init_busy         : clear in progress, port unavailable
//   wr_err            : one-cycle pulse, previous cycle's write was dropped
module dual_port_sram_param
  import dual_port_sram_pkg::*;
#(
  parameter int                 DATA_W    = 8,
  parameter int                 ADDR_W    = 4,
  parameter int                 DEPTH     = 16,
  parameter int                 READ_MODE = READ_ASYNC,
  parameter int                 RDW_MODE  = RDW_WRITE_FIRST,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] ad_wr,
  input  logic [DATA_W-1:0] wr_d,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] ad_rd,
  output logic [DATA_W-1:0] rd_d,
  output logic              rd_valid,
  output logic              init_busy,
  output logic              wr_err
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  sram_init_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init (
    .clk       (clk),
    .rst       (rst),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  logic wr_in_rng, rd_in_rng, wr_ok;
  assign wr_in_rng = ({1'b0, ad_wr} < DEPTH_L);
  assign rd_in_rng = ({1'b0, ad_rd} < DEPTH_L);
  assign wr_ok     = w_en & wr_in_rng & ~init_busy;

  // Write-port mux: the clear sequencer owns the port during INIT.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  assign mem_we = clr_we | wr_ok;
  assign mem_wa = clr_we ? clr_addr : ad_wr;
  assign mem_wd = clr_we ? CLEAR_VAL : wr_d;

  // Storage has no reset. While rst is held the sequencer sits at word 0
  // and rewrites it with CLEAR_VAL, which the restarted clear redoes anyway.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Dropped write: during INIT or out of range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_err <= 1'b0;
    else     wr_err <= w_en & (init_busy | ~wr_in_rng);
  end

  // Raw array read; out-of-range addresses return zero rather than X.
  logic [DATA_W-1:0] mem_rd;
  assign mem_rd = rd_in_rng ? mem[ad_rd] : '0;

  generate
    if (READ_MODE == READ_SYNC) begin : g_sync
      logic [DATA_W-1:0] rd_q;
      logic              vld_q;
      logic              rdw_hit;

      // Only an accepted write can collide with the read.
      assign rdw_hit = wr_ok & (ad_wr == ad_rd);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_q  <= '0;
          vld_q <= 1'b0;
        end else if (init_busy || !r_en) begin
          vld_q <= 1'b0;
        end else begin
          vld_q <= 1'b1;
          // mem_rd still shows the pre-edge contents, i.e. read-first.
          rd_q  <= (RDW_MODE == RDW_WRITE_FIRST && rdw_hit) ? wr_d : mem_rd;
        end
      end

      assign rd_d     = rd_q;
      assign rd_valid = vld_q;
    end else begin : g_async
      assign rd_d     = init_busy ? '0 : mem_rd;
      assign rd_valid = r_en & ~init_busy;
    end
  endgenerate

endmodule
